// File: rtl/oh_pwrseq.sv
// Power-domain sequencer: staggers PMOS header segments on/off, then manages
// isolation and domain reset around the powered window.
module oh_pwrseq #(
   parameter int    N       = 4,
   parameter int    DELAY   = 8,
   parameter int    TIMEOUT = 64,
   parameter string DEBUG   = "false"
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         req_on,
   input  logic         pgood,
   output logic [N-1:0] pwr_en_n,
   output logic         iso,
   output logic         domain_nreset,
   output logic         ack,
   output logic         busy,
   output logic         fault
);
   localparam int         IW   = $clog2(N);
   localparam logic [7:0]  DLY = 8'(DELAY - 1);
   localparam logic [15:0] TMO = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      OFF, RAMP_UP, WAIT_PG, ISO_REL, ON, RAMP_DN, FAULT
   } state_t;

   state_t          state, state_n;
   logic [N-1:0]    pwr_n;
   logic [IW-1:0]   idx, idx_n, idx_p1;
   logic [7:0]      dcnt, dcnt_n;
   logic [15:0]     tcnt, tcnt_n;
   logic [1:0]      pre, pre_n;
   logic            iso_n, dnr_n;

   // idx tracks the highest enabled segment; pre sequences reset-then-first-disable
   // when leaving a powered state.
   always_comb begin
      state_n = state;
      pwr_n   = pwr_en_n;
      idx_n   = idx;
      idx_p1  = idx + 1'b1;
      dcnt_n  = dcnt;
      tcnt_n  = tcnt;
      pre_n   = pre;
      iso_n   = iso;
      dnr_n   = domain_nreset;
      case (state)
         OFF: begin
            pwr_n = '1; iso_n = 1'b1; dnr_n = 1'b0; idx_n = '0;
            if (req_on) begin
               state_n  = RAMP_UP;
               pwr_n[0] = 1'b0;
               dcnt_n   = '0;
            end
         end
         RAMP_UP, WAIT_PG: begin
            if (!req_on) begin
               pwr_n[idx] = 1'b1;
               dcnt_n     = '0;
               pre_n      = '0;
               if (idx == '0) state_n = OFF;
               else begin
                  idx_n   = idx - 1'b1;
                  state_n = RAMP_DN;
               end
            end else if (state == RAMP_UP) begin
               if (dcnt == DLY) begin
                  dcnt_n        = '0;
                  idx_n         = idx_p1;
                  pwr_n[idx_p1] = 1'b0;
                  if (idx_p1 == IW'(N - 1)) begin
                     state_n = WAIT_PG;
                     tcnt_n  = '0;
                  end
               end else dcnt_n = dcnt + 8'd1;
            end else if (pgood) begin
               state_n = ISO_REL;
               iso_n   = 1'b0;
            end else if (tcnt == TMO) begin
               state_n = FAULT;
               pwr_n   = '1;
            end else tcnt_n = tcnt + 16'd1;
         end
         ISO_REL, ON: begin
            if (!req_on) begin
               state_n = RAMP_DN;
               iso_n   = 1'b1;
               pre_n   = 2'd2;
            end else if (state == ISO_REL) begin
               state_n = ON;
               dnr_n   = 1'b1;
            end
         end
         RAMP_DN: begin
            if (pre == 2'd2) begin
               dnr_n = 1'b0;
               pre_n = 2'd1;
            end else if (pre == 2'd1 || dcnt == DLY) begin
               pre_n      = '0;
               dcnt_n     = '0;
               pwr_n[idx] = 1'b1;
               if (idx == '0) state_n = OFF;
               else idx_n = idx - 1'b1;
            end else dcnt_n = dcnt + 8'd1;
         end
         FAULT: begin
            pwr_n = '1; iso_n = 1'b1; dnr_n = 1'b0;
            if (!req_on) state_n = OFF;
         end
         default: state_n = OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state         <= OFF;
         pwr_en_n      <= '1;
         idx           <= '0;
         dcnt          <= '0;
         tcnt          <= '0;
         pre           <= '0;
         iso           <= 1'b1;
         domain_nreset <= 1'b0;
         ack           <= 1'b0;
         busy          <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state         <= state_n;
         pwr_en_n      <= pwr_n;
         idx           <= idx_n;
         dcnt          <= dcnt_n;
         tcnt          <= tcnt_n;
         pre           <= pre_n;
         iso           <= iso_n;
         domain_nreset <= dnr_n;
         ack           <= (state_n == ON);
         busy          <= (state_n == RAMP_UP) || (state_n == WAIT_PG) ||
                          (state_n == ISO_REL) || (state_n == RAMP_DN);
         fault         <= (state_n == FAULT);
      end
   end

   generate
      if (DEBUG == "true") begin : g_debug
         always_ff @(posedge clk) begin
            if (nreset && state_n != state)
               $display("%m: %s -> %s", state.name(), state_n.name());
         end
      end
   endgenerate
endmodule

// File: tb/tb_oh_pwrseq.sv
// Directed bench for oh_pwrseq (N=4, DELAY=8, TIMEOUT=64).
module tb_oh_pwrseq;
   logic       clk = 1'b0;
   logic       nreset, req_on, pgood;
   logic [3:0] pwr_en_n;
   logic       iso, domain_nreset, ack, busy, fault;
   int         passed = 0, total = 0, viol = 0;

   oh_pwrseq #(.N(4), .DELAY(8), .TIMEOUT(64), .DEBUG("false")) dut (
      .clk(clk), .nreset(nreset), .req_on(req_on), .pgood(pgood),
      .pwr_en_n(pwr_en_n), .iso(iso), .domain_nreset(domain_nreset),
      .ack(ack), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   // Isolation released or reset deasserted while any segment is still off.
   always @(posedge clk) begin
      #2;
      if (nreset === 1'b1 && (iso === 1'b0 || domain_nreset === 1'b1) && (|pwr_en_n))
         viol++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      nreset = 1'b0; req_on = 1'b0; pgood = 1'b0;
      tickn(2);
      total++; if ({pwr_en_n, iso, domain_nreset, ack, busy, fault} !== 9'b1111_1_0_0_0_0)
         $display("FAIL reset: got %b want %b", {pwr_en_n, iso, domain_nreset, ack, busy, fault}, 9'b1111_1_0_0_0_0); else passed++;
      nreset = 1'b1;
      tickn(2);
      total++; if (pwr_en_n !== 4'b1111 || busy !== 1'b0) $display("FAIL idle: pwr=%b busy=%b want 1111/0", pwr_en_n, busy); else passed++;
   endtask

   task automatic test_power_up();
      pgood = 1'b1; req_on = 1'b1;
      tick();  // t0
      total++; if (pwr_en_n !== 4'b1110 || busy !== 1'b1) $display("FAIL up_t0: pwr=%b busy=%b want 1110/1", pwr_en_n, busy); else passed++;
      tickn(7);
      total++; if (pwr_en_n !== 4'b1110) $display("FAIL up_t7: pwr=%b want 1110", pwr_en_n); else passed++;
      tick();
      total++; if (pwr_en_n !== 4'b1100) $display("FAIL up_t8: pwr=%b want 1100", pwr_en_n); else passed++;
      tickn(8);
      total++; if (pwr_en_n !== 4'b1000) $display("FAIL up_t16: pwr=%b want 1000", pwr_en_n); else passed++;
      tickn(8);
      total++; if (pwr_en_n !== 4'b0000 || iso !== 1'b1) $display("FAIL up_t24: pwr=%b iso=%b want 0000/1", pwr_en_n, iso); else passed++;
      tick();
      total++; if (iso !== 1'b0 || ack !== 1'b0 || domain_nreset !== 1'b0) $display("FAIL up_t25: iso=%b ack=%b dnr=%b want 0/0/0", iso, ack, domain_nreset); else passed++;
      tick();
      total++; if (ack !== 1'b1 || domain_nreset !== 1'b1 || busy !== 1'b0) $display("FAIL up_t26: ack=%b dnr=%b busy=%b want 1/1/0", ack, domain_nreset, busy); else passed++;
   endtask

   task automatic test_pgood_drop();
      pgood = 1'b0;
      tickn(5);
      total++; if (ack !== 1'b1 || fault !== 1'b0) $display("FAIL pgood_drop: ack=%b fault=%b want 1/0", ack, fault); else passed++;
      pgood = 1'b1;
   endtask

   task automatic test_power_down(input logic req_back);
      req_on = 1'b0;
      tick();  // t1
      req_on = req_back;
      total++; if (iso !== 1'b1 || ack !== 1'b0 || domain_nreset !== 1'b1) $display("FAIL dn_t1: iso=%b ack=%b dnr=%b want 1/0/1", iso, ack, domain_nreset); else passed++;
      tick();
      total++; if (domain_nreset !== 1'b0 || pwr_en_n !== 4'b0000) $display("FAIL dn_t1p1: dnr=%b pwr=%b want 0/0000", domain_nreset, pwr_en_n); else passed++;
      tick();
      total++; if (pwr_en_n !== 4'b1000) $display("FAIL dn_t2: pwr=%b want 1000", pwr_en_n); else passed++;
      tickn(8);
      total++; if (pwr_en_n !== 4'b1100) $display("FAIL dn_t10: pwr=%b want 1100", pwr_en_n); else passed++;
      tickn(8);
      total++; if (pwr_en_n !== 4'b1110) $display("FAIL dn_t18: pwr=%b want 1110", pwr_en_n); else passed++;
      tickn(7);
      total++; if (pwr_en_n !== 4'b1110 || busy !== 1'b1) $display("FAIL dn_t25: pwr=%b busy=%b want 1110/1", pwr_en_n, busy); else passed++;
      tick();
      total++; if (pwr_en_n !== 4'b1111 || busy !== 1'b0) $display("FAIL dn_t26: pwr=%b busy=%b want 1111/0", pwr_en_n, busy); else passed++;
   endtask

   task automatic test_restart_after_dn();
      // req_on has been high throughout the ramp-down; OFF restarts on the next edge.
      tick();
      total++; if (pwr_en_n !== 4'b1110 || busy !== 1'b1) $display("FAIL restart: pwr=%b busy=%b want 1110/1", pwr_en_n, busy); else passed++;
   endtask

   task automatic test_reset_mid_ramp();
      tickn(11);  // t0+11, counting from the restart edge
      nreset = 1'b0;
      tick();     // t0+12
      total++; if ({pwr_en_n, iso, domain_nreset, ack, busy, fault} !== 9'b1111_1_0_0_0_0)
         $display("FAIL mid_reset: got %b want %b", {pwr_en_n, iso, domain_nreset, ack, busy, fault}, 9'b1111_1_0_0_0_0); else passed++;
      nreset = 1'b1;
      tick();
      total++; if (pwr_en_n !== 4'b1110) $display("FAIL mid_restart: pwr=%b want 1110", pwr_en_n); else passed++;
      tickn(8);
      total++; if (pwr_en_n !== 4'b1100) $display("FAIL mid_restart_t8: pwr=%b want 1100", pwr_en_n); else passed++;
      nreset = 1'b0; req_on = 1'b0;
      tick();
      nreset = 1'b1;
      tick();
   endtask

   task automatic test_timeout();
      pgood = 1'b0; req_on = 1'b1;
      tick();      // t0
      tickn(24);   // WAIT_PG entry edge
      total++; if (pwr_en_n !== 4'b0000 || fault !== 1'b0) $display("FAIL to_entry: pwr=%b fault=%b want 0000/0", pwr_en_n, fault); else passed++;
      tickn(63);
      total++; if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL to_63: fault=%b busy=%b want 0/1", fault, busy); else passed++;
      tick();
      total++; if (fault !== 1'b1 || pwr_en_n !== 4'b1111 || iso !== 1'b1 || busy !== 1'b0)
         $display("FAIL to_64: fault=%b pwr=%b iso=%b busy=%b want 1/1111/1/0", fault, pwr_en_n, iso, busy); else passed++;
      pgood = 1'b1;
      tickn(3);
      total++; if (fault !== 1'b1) $display("FAIL to_hold: fault=%b want 1", fault); else passed++;
      req_on = 1'b0;
      tick();
      total++; if (fault !== 1'b0 || pwr_en_n !== 4'b1111) $display("FAIL to_clear: fault=%b pwr=%b want 0/1111", fault, pwr_en_n); else passed++;
      tick();
   endtask

   task automatic test_abort();
      logic saw_ack = 1'b0;
      pgood = 1'b1; req_on = 1'b1;
      tick();      // t0
      for (int i = 0; i < 9; i++) begin tick(); saw_ack |= ack; end
      total++; if (pwr_en_n !== 4'b1100) $display("FAIL ab_t9: pwr=%b want 1100", pwr_en_n); else passed++;
      req_on = 1'b0;
      tick();      // t0+10
      saw_ack |= ack;
      total++; if (pwr_en_n !== 4'b1110 || iso !== 1'b1 || domain_nreset !== 1'b0) $display("FAIL ab_t10: pwr=%b iso=%b dnr=%b want 1110/1/0", pwr_en_n, iso, domain_nreset); else passed++;
      for (int i = 0; i < 7; i++) begin tick(); saw_ack |= ack; end
      total++; if (pwr_en_n !== 4'b1110) $display("FAIL ab_t17: pwr=%b want 1110", pwr_en_n); else passed++;
      tick();      // t0+18
      saw_ack |= ack;
      total++; if (pwr_en_n !== 4'b1111 || busy !== 1'b0) $display("FAIL ab_t18: pwr=%b busy=%b want 1111/0", pwr_en_n, busy); else passed++;
      tickn(2);
      total++; if (saw_ack !== 1'b0 || pwr_en_n !== 4'b1111) $display("FAIL ab_ack: ack_seen=%b pwr=%b want 0/1111", saw_ack, pwr_en_n); else passed++;
   endtask

   initial begin
      nreset = 1'b0; req_on = 1'b0; pgood = 1'b0;
      test_reset();
      test_power_up();
      test_pgood_drop();
      test_power_down(1'b0);
      test_power_up();
      test_power_down(1'b1);
      test_restart_after_dn();
      test_reset_mid_ramp();
      test_timeout();
      test_abort();
      total++; if (viol !== 0) $display("FAIL invariant: violations=%0d want 0", viol); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, want completion");
      $fatal(1, "watchdog");
   end
endmodule
